// File: rtl/dmem_responder_if.sv
// Data-memory port between the memory-access stage (master) and the responder (slave).
// Signal names keep the responder's point of view: _i flows into it, _o flows out.
interface dmem_responder_if;
   logic [31:0] dmem_addr_i;
   logic [31:0] dmem_write_data_i;
   logic [3:0]  dmem_write_mask_i;
   logic [31:0] dmem_read_data_o;

   modport master (
      output dmem_addr_i,
      output dmem_write_data_i,
      output dmem_write_mask_i,
      input  dmem_read_data_o
   );

   modport slave (
      input  dmem_addr_i,
      input  dmem_write_data_i,
      input  dmem_write_mask_i,
      output dmem_read_data_o
   );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM plus a 16-byte MMIO window holding a tear-free
// 64-bit cycle counter, a sticky tohost/halt register and a scratch register.
module dmem_responder #(
   parameter int unsigned MEM_WORDS = 4096,
   parameter logic [31:0] MMIO_BASE = 32'hFF00_0000
) (
   input  logic              clk_i,
   input  logic              reset_i,
   dmem_responder_if.slave   bus,
   output logic [31:0]       tohost_o,
   output logic              halt_o
);

   localparam int unsigned AW = $clog2(MEM_WORDS);

   typedef enum logic [1:0] {
      MMIO_CYCLE_LO = 2'd0,
      MMIO_CYCLE_HI = 2'd1,
      MMIO_TOHOST   = 2'd2,
      MMIO_SCRATCH  = 2'd3
   } mmio_reg_e;

   logic [31:0]   w_addr;
   logic [31:0]   w_wdata;
   logic [3:0]    w_mask;
   logic          w_is_ram;
   logic          w_is_mmio;
   logic          w_write;
   logic [AW-1:0] w_ram_idx;
   mmio_reg_e     w_mmio_reg;
   logic [31:0]   w_read_next;
   logic          w_unused_addr;

   logic [31:0] r_mem [MEM_WORDS];
   logic [31:0] r_read_data;
   logic [63:0] r_cycle;
   logic [31:0] r_shadow;
   logic [31:0] r_tohost;
   logic [31:0] r_scratch;
   logic        r_halt;

   assign w_addr        = bus.dmem_addr_i;
   assign w_wdata       = bus.dmem_write_data_i;
   assign w_mask        = bus.dmem_write_mask_i;
   assign w_unused_addr = ^w_addr[1:0];

   // The MMIO window is 16-byte aligned, so its decode ignores the low nibble.
   assign w_is_ram   = (w_addr[31:AW+2] == '0);
   assign w_is_mmio  = (w_addr[31:4] == MMIO_BASE[31:4]);
   assign w_ram_idx  = w_addr[AW+1:2];
   assign w_mmio_reg = mmio_reg_e'(w_addr[3:2]);
   assign w_write    = |w_mask;

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  mask);
      logic [31:0] result;
      result = old_word;
      for (int b = 0; b < 4; b++) begin
         if (mask[b]) result[8*b +: 8] = new_word[8*b +: 8];
      end
      return result;
   endfunction

   // NOTE: RAM has no reset so it maps onto block RAM; contents are undefined until written.
   always_ff @(posedge clk_i) begin
      if (w_is_ram) begin
         for (int b = 0; b < 4; b++) begin
            if (w_mask[b]) r_mem[w_ram_idx][8*b +: 8] <= w_wdata[8*b +: 8];
         end
      end
   end

   // NOTE: every output of an always_comb gets a default first so no latch is inferred.
   always_comb begin
      w_read_next = '0;
      if (w_is_ram) begin
         w_read_next = r_mem[w_ram_idx];
      end else if (w_is_mmio) begin
         case (w_mmio_reg)
            MMIO_CYCLE_LO: w_read_next = r_cycle[31:0];
            MMIO_CYCLE_HI: w_read_next = r_shadow;
            MMIO_TOHOST:   w_read_next = r_tohost;
            MMIO_SCRATCH:  w_read_next = r_scratch;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values;
   // this is also what makes RAM reads and the shadow latch see the old word.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_read_data <= '0;
         r_cycle     <= '0;
         r_shadow    <= '0;
         r_tohost    <= '0;
         r_scratch   <= '0;
         r_halt      <= 1'b0;
      end else begin
         r_read_data <= w_read_next;
         r_cycle     <= r_cycle + 64'd1;
         if (w_is_mmio) begin
            case (w_mmio_reg)
               MMIO_CYCLE_LO: r_shadow <= r_cycle[63:32];
               MMIO_TOHOST: begin
                  if (w_write) begin
                     r_tohost <= merge_bytes(r_tohost, w_wdata, w_mask);
                     r_halt   <= 1'b1;
                  end
               end
               MMIO_SCRATCH: begin
                  if (w_write) r_scratch <= merge_bytes(r_scratch, w_wdata, w_mask);
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.dmem_read_data_o = r_read_data;
   assign tohost_o             = r_tohost;
   assign halt_o               = r_halt;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: RAM byte masks, read-first, MMIO counter/halt, unmapped, reset.
module tb_dmem_responder;

   localparam logic [31:0] BASE = 32'hFF00_0000;
   localparam logic [31:0] UNMAPPED = 32'h8000_0000;

   logic        clk_i;
   logic        reset_i;
   logic [31:0] tohost_o;
   logic        halt_o;
   logic [63:0] cyc;
   int          n_cmp;
   int          n_fail;

   dmem_responder_if bus ();

   dmem_responder #(
      .MEM_WORDS (4096),
      .MMIO_BASE (BASE)
   ) dut (
      .clk_i    (clk_i),
      .reset_i  (reset_i),
      .bus      (bus),
      .tohost_o (tohost_o),
      .halt_o   (halt_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic present(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
      bus.dmem_addr_i       = a;
      bus.dmem_write_data_i = d;
      bus.dmem_write_mask_i = m;
   endtask

   // Advance one cycle; cyc tracks the counter value the DUT holds in the new cycle.
   task automatic tick();
      @(negedge clk_i);
      cyc = cyc + 64'd1;
   endtask

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      cyc    = '0;
      reset_i = 1'b1;
      present(BASE, 32'h0, 4'b0000);
      #1;
      check("reset_rdata", {32'h0, bus.dmem_read_data_o}, 64'h0);
      check("reset_tohost", {32'h0, tohost_o}, 64'h0);
      check("reset_halt", {63'h0, halt_o}, 64'h0);

      // First post-reset cycle: CYCLE_LO must read 0, the next one 1.
      @(negedge clk_i);
      reset_i = 1'b0;
      cyc = '0;
      tick();
      check("first_lo", {32'h0, bus.dmem_read_data_o}, 64'h0);
      tick();
      check("second_lo", {32'h0, bus.dmem_read_data_o}, 64'h1);

      // Byte-masked RAM write.
      present(32'h10, 32'hDEAD_BEEF, 4'b1111); tick();
      present(32'h10, 32'h5555_5555, 4'b0010); tick();
      present(32'h10, 32'h0, 4'b0000);         tick();
      check("mask_merge", {32'h0, bus.dmem_read_data_o}, 64'hDEAD_55EF);

      // Read-first on same-cycle read/write.
      present(32'h20, 32'h1, 4'b1111); tick();
      present(32'h20, 32'h2, 4'b1111); tick();
      check("read_first_old", {32'h0, bus.dmem_read_data_o}, 64'h1);
      present(32'h20, 32'h0, 4'b0000); tick();
      check("read_first_new", {32'h0, bus.dmem_read_data_o}, 64'h2);

      // RAM top boundary and unmapped accesses must not alias onto word 0 or MMIO.
      present(32'h0,    32'h1234_5678, 4'b1111); tick();
      present(32'h3FFC, 32'hCAFE_F00D, 4'b1111); tick();
      present(BASE + 32'hC, 32'hA5A5_5A5A, 4'b1111); tick();
      present(32'h4000, 32'hFFFF_FFFF, 4'b1111); tick();
      check("above_ram_rd", {32'h0, bus.dmem_read_data_o}, 64'h0);
      present(UNMAPPED, 32'hFFFF_FFFF, 4'b1111); tick();
      check("unmapped_rd", {32'h0, bus.dmem_read_data_o}, 64'h0);
      present(32'h3FFC, 32'h0, 4'b0000); tick();
      check("ram_top_word", {32'h0, bus.dmem_read_data_o}, 64'hCAFE_F00D);
      present(32'h0, 32'h0, 4'b0000); tick();
      check("ram_word0_kept", {32'h0, bus.dmem_read_data_o}, 64'h1234_5678);
      present(BASE + 32'hC, 32'h1100_0000, 4'b1000); tick();
      check("scratch_kept", {32'h0, bus.dmem_read_data_o}, 64'hA5A5_5A5A);
      present(BASE + 32'hC, 32'h0, 4'b0000); tick();
      check("scratch_masked", {32'h0, bus.dmem_read_data_o}, 64'h11A5_5A5A);
      check("halt_idle", {63'h0, halt_o}, 64'h0);

      // Counter registers ignore writes.
      begin
         logic [63:0] exp_cnt;
         exp_cnt = cyc;
         present(BASE, 32'hFFFF_FFFF, 4'b1111); tick();
         check("lo_write_ign", {32'h0, bus.dmem_read_data_o}, {32'h0, exp_cnt[31:0]});
      end
      present(BASE + 32'h4, 32'hFFFF_FFFF, 4'b1111); tick();
      check("hi_write_ign", {32'h0, bus.dmem_read_data_o}, 64'h0);

      // TOHOST and sticky halt.
      present(BASE + 32'h8, 32'h0000_0001, 4'b0001); tick();
      check("tohost_set", {32'h0, tohost_o}, 64'h1);
      check("halt_set", {63'h0, halt_o}, 64'h1);
      present(BASE + 32'h8, 32'h0, 4'b1111); tick();
      check("tohost_rd_old", {32'h0, bus.dmem_read_data_o}, 64'h1);
      check("tohost_zero", {32'h0, tohost_o}, 64'h0);
      check("halt_sticky", {63'h0, halt_o}, 64'h1);
      present(BASE + 32'h8, 32'hAABB_CCDD, 4'b0100); tick();
      check("tohost_masked", {32'h0, tohost_o}, 64'h00BB_0000);

      // Counter carry into the upper word: LO/HI pair stays consistent.
      force dut.r_cycle = 64'h0000_0000_FFFF_FFFE;
      release dut.r_cycle;
      cyc = 64'h0000_0000_FFFF_FFFE;
      present(UNMAPPED, 32'h0, 4'b0000); tick();
      present(BASE, 32'h0, 4'b0000); tick();
      check("carry_lo", {32'h0, bus.dmem_read_data_o}, 64'hFFFF_FFFF);
      present(BASE + 32'h4, 32'h0, 4'b0000); tick();
      check("carry_hi_shadow", {32'h0, bus.dmem_read_data_o}, 64'h0);
      check("carry_live", cyc, 64'h1_0000_0001);
      present(BASE, 32'h0, 4'b0000); tick();
      check("post_carry_lo", {32'h0, bus.dmem_read_data_o}, 64'h1);
      present(BASE + 32'h4, 32'h0, 4'b0000); tick();
      check("post_carry_hi", {32'h0, bus.dmem_read_data_o}, 64'h1);

      // Asynchronous reset after 100 cycles, with a TOHOST write in flight.
      present(BASE + 32'hC, 32'h0, 4'b0000);
      for (int i = 0; i < 100; i++) tick();
      check("pre_reset_rd", {32'h0, bus.dmem_read_data_o}, 64'h11A5_5A5A);
      present(BASE + 32'h8, 32'h0000_0055, 4'b1111);
      #2;
      reset_i = 1'b1;
      #1;
      check("async_rdata", {32'h0, bus.dmem_read_data_o}, 64'h0);
      check("async_halt", {63'h0, halt_o}, 64'h0);
      check("async_tohost", {32'h0, tohost_o}, 64'h0);
      check("async_cycle", dut.r_cycle, 64'h0);
      @(negedge clk_i);
      reset_i = 1'b0;
      cyc = '0;
      present(BASE, 32'h0, 4'b0000); tick();
      check("post_reset_lo", {32'h0, bus.dmem_read_data_o}, 64'h0);
      check("post_reset_tohost", {32'h0, tohost_o}, 64'h0);
      check("post_reset_halt", {63'h0, halt_o}, 64'h0);
      present(BASE + 32'hC, 32'h0, 4'b0000); tick();
      check("post_reset_scratch", {32'h0, bus.dmem_read_data_o}, 64'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
